// File: rtl/mu_alu_pkg.sv
// Shared definitions for the mu-cost fixed-point ALU: op and state encodings,
// flag bit positions and the saturation helpers.
package mu_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD       = 3'd0,
      OP_SUB       = 3'd1,
      OP_MUL       = 3'd2,
      OP_DIV       = 3'd3,
      OP_LOG2      = 3'd4,
      OP_INFO_GAIN = 3'd5,
      OP_ABS       = 3'd6,
      OP_ILLEGAL   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_DIV,
      ST_DONE
   } state_e;

   localparam int unsigned FLG_OVF = 0;
   localparam int unsigned FLG_DZ  = 1;
   localparam int unsigned FLG_ILL = 2;

   // Helpers work on a fixed wide container; callers keep the low w bits.
   localparam int unsigned MAX_W = 64;

   function automatic logic [MAX_W-1:0] minv(input int unsigned w);
      logic [MAX_W-1:0] one;
      one = MAX_W'(1);
      return one << (w - 1);
   endfunction

   function automatic logic [MAX_W-1:0] maxv(input int unsigned w);
      return minv(w) - MAX_W'(1);
   endfunction

   function automatic logic [MAX_W-1:0] sat_val(input logic             ovf,
                                                input logic             neg,
                                                input logic [MAX_W-1:0] wrapped,
                                                input int unsigned      w,
                                                input logic             sat_en);
      if (ovf && sat_en)
         return neg ? minv(w) : maxv(w);
      return wrapped;
   endfunction

endpackage

// File: rtl/mu_alu_seq_if.sv
// Request/response handshake bundle between the mu-ledger controller (master)
// and the ALU (slave).
interface mu_alu_seq_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [2:0]       flags;

   modport master (
      output in_valid, op, operand_a, operand_b, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, op, operand_a, operand_b, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/mu_div_seq.sv
// Sequential restoring divider on magnitudes: (dividend << FRAC) / divisor,
// one quotient bit per clock, WIDTH+FRAC iterations.
module mu_div_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FRAC  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      dividend,
   input  logic [WIDTH-1:0]      divisor,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH+FRAC-1:0] quotient
);
   localparam int unsigned QW = WIDTH + FRAC;
   localparam int unsigned CW = $clog2(QW + 1);

   logic          busy_q, done_q;
   logic [CW-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q, dvs_q, diff;
   logic [QW-1:0] sh_q;
   logic [WIDTH:0] trial;
   logic          fits;

   // sh_q shifts dividend bits out at the top while quotient bits enter at the bottom.
   always_comb begin
      trial = {rem_q, sh_q[QW-1]};
      fits  = (trial >= {1'b0, dvs_q});
      diff  = trial[WIDTH-1:0] - dvs_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         sh_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= divisor;
            sh_q   <= {dividend, {FRAC{1'b0}}};
         end else if (busy_q) begin
            sh_q  <= {sh_q[QW-2:0], fits};
            rem_q <= fits ? diff : trial[WIDTH-1:0];
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(QW - 1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = sh_q;
endmodule

// File: rtl/mu_alu_seq.sv
// Qm.f saturating fixed-point ALU with valid/ready handshake, sequential divide
// and linear-mantissa log2; one operation in flight.
import mu_alu_pkg::*;

module mu_alu_seq #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned FRAC     = 16,
   parameter bit          SATURATE = 1'b1
) (
   input logic         clk,
   input logic         rst_n,
   mu_alu_seq_if.slave bus
);
   localparam int unsigned      QW     = WIDTH + FRAC;
   localparam logic [MAX_W-1:0] MAXV_X = maxv(WIDTH);
   localparam logic [MAX_W-1:0] MINV_X = minv(WIDTH);
   localparam logic [WIDTH-1:0] MAXV   = MAXV_X[WIDTH-1:0];
   localparam logic [WIDTH-1:0] MINV   = MINV_X[WIDTH-1:0];

   state_e           state_q, state_d;
   logic             accept, div_start, div_busy, div_done;
   logic [WIDTH-1:0] a_q, b_q, res_q, exec_res, div_res, div_wrap;
   logic [WIDTH-1:0] a_mag_in, b_mag_in;
   logic [2:0]       flg_q, exec_flg;
   op_e              op_q;
   logic [QW-1:0]    div_q;
   logic             div_neg, div_ovf;

   logic [WIDTH:0]     sum, dif;
   logic [2*WIDTH-1:0] prod, prod_sh;
   logic               mul_fit, a_pos;
   int unsigned        lg_p;
   logic [WIDTH-1:0]   lg_ip, lg_res;
   logic [FRAC-1:0]    lg_frac;

   function automatic logic [WIDTH-1:0] clamp(input logic             ovf,
                                              input logic             neg,
                                              input logic [WIDTH-1:0] wrapped);
      logic [MAX_W-1:0] t;
      t = sat_val(ovf, neg, MAX_W'(wrapped), WIDTH, SATURATE);
      return t[WIDTH-1:0];
   endfunction

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      div_start = 1'b0;
      case (state_q)
         ST_IDLE:
            if (bus.in_valid) begin
               accept = 1'b1;
               if (bus.op == OP_DIV && bus.operand_b != '0) begin
                  state_d   = ST_DIV;
                  div_start = !div_busy;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         ST_EXEC: state_d = ST_DONE;
         ST_DIV:  if (div_done) state_d = ST_DONE;
         ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      a_mag_in = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
      b_mag_in = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;
   end

   // Divider is launched straight off the bus so the accept edge is its load edge.
   mu_div_seq #(.WIDTH(WIDTH), .FRAC(FRAC)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend (a_mag_in),
      .divisor  (b_mag_in),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_q)
   );

   always_comb begin
      div_neg  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
      div_ovf  = div_neg ? (div_q > QW'(MINV)) : (div_q > QW'(MAXV));
      div_wrap = div_neg ? -div_q[WIDTH-1:0] : div_q[WIDTH-1:0];
      div_res  = clamp(div_ovf, div_neg, div_wrap);
   end

   always_comb begin
      sum     = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
      dif     = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
      prod    = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
      prod_sh = $signed(prod) >>> FRAC;
      mul_fit = (prod_sh[2*WIDTH-1:WIDTH-1] == '0) || (prod_sh[2*WIDTH-1:WIDTH-1] == '1);
      a_pos   = !a_q[WIDTH-1] && (a_q != '0);

      lg_p = 0;
      for (int unsigned i = 0; i < WIDTH; i++)
         if (a_q[i]) lg_p = i;
      // Left-justify below the leading one, then keep the top FRAC bits as the fraction.
      lg_frac = FRAC'((a_q << (WIDTH - 1 - lg_p)) >> (WIDTH - 1 - FRAC));
      lg_ip   = WIDTH'(lg_p) - WIDTH'(FRAC);
      lg_res  = (lg_ip << FRAC) | WIDTH'(lg_frac);

      exec_res = '0;
      exec_flg = '0;
      case (op_q)
         OP_ADD: begin
            exec_res           = clamp(sum[WIDTH] ^ sum[WIDTH-1], sum[WIDTH], sum[WIDTH-1:0]);
            exec_flg[FLG_OVF]  = sum[WIDTH] ^ sum[WIDTH-1];
         end
         OP_SUB: begin
            exec_res           = clamp(dif[WIDTH] ^ dif[WIDTH-1], dif[WIDTH], dif[WIDTH-1:0]);
            exec_flg[FLG_OVF]  = dif[WIDTH] ^ dif[WIDTH-1];
         end
         OP_MUL: begin
            exec_res           = clamp(!mul_fit, prod[2*WIDTH-1], prod_sh[WIDTH-1:0]);
            exec_flg[FLG_OVF]  = !mul_fit;
         end
         OP_DIV: begin
            exec_res           = a_q[WIDTH-1] ? MINV : MAXV;
            exec_flg[FLG_DZ]   = 1'b1;
            exec_flg[FLG_OVF]  = 1'b1;
         end
         OP_LOG2: begin
            exec_res           = a_pos ? lg_res : MINV;
            exec_flg[FLG_OVF]  = !a_pos;
         end
         OP_INFO_GAIN: begin
            if (b_q == '0) begin
               exec_flg[FLG_DZ] = 1'b1;
            end else begin
               exec_res          = clamp(dif[WIDTH] ^ dif[WIDTH-1], dif[WIDTH], dif[WIDTH-1:0]);
               exec_flg[FLG_OVF] = dif[WIDTH] ^ dif[WIDTH-1];
            end
         end
         OP_ABS: begin
            exec_res           = clamp(a_q == MINV, 1'b0, a_q[WIDTH-1] ? -a_q : a_q);
            exec_flg[FLG_OVF]  = (a_q == MINV);
         end
         default: exec_flg[FLG_ILL] = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= OP_ADD;
         res_q <= '0;
         flg_q <= '0;
      end else if (accept) begin
         a_q   <= bus.operand_a;
         b_q   <= bus.operand_b;
         op_q  <= op_e'(bus.op);
         flg_q <= '0;
      end else if (state_q == ST_EXEC) begin
         res_q <= exec_res;
         flg_q <= exec_flg;
      end else if (state_q == ST_DIV && div_done) begin
         res_q          <= div_res;
         flg_q          <= '0;
         flg_q[FLG_OVF] <= div_ovf;
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.result    = res_q;
   assign bus.flags     = flg_q;
endmodule

// File: tb/tb_mu_alu_seq.sv
// Scoreboard bench for mu_alu_seq at WIDTH=32, FRAC=16, saturating.
module tb_mu_alu_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int unsigned cyc = 0;
   int unsigned n_total = 0;
   int unsigned n_bad = 0;

   typedef struct {
      logic [31:0] res;
      logic [2:0]  flg;
      logic [2:0]  op;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;

   mu_alu_seq_if #(.WIDTH(32)) bus ();

   mu_alu_seq #(.WIDTH(32), .FRAC(16), .SATURATE(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sbq.size() == 0) begin
            chk("sb_underflow", 64'(sbq.size()), 64'd1);
         end else begin
            mon_e = sbq.pop_front();
            chk($sformatf("result_op%0d", mon_e.op), bus.result, mon_e.res);
            chk($sformatf("flags_op%0d", mon_e.op), bus.flags, mon_e.flg);
         end
      end
   end

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [2:0] ef,
                         input int unsigned el, input int unsigned hold);
      int unsigned acc;
      bit seen;
      exp_t e;
      bus.op        = op;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.in_valid  = 1'b1;
      bus.out_ready = (hold == 0);
      e.res = er; e.flg = ef; e.op = op;
      sbq.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin seen = 1'b1; break; end
      end
      if (!seen) chk("in_ready_timeout", bus.in_ready, 1);
      @(posedge clk); #1;
      acc = cyc;
      bus.in_valid  = 1'b0;
      bus.operand_a = ~a;
      bus.operand_b = ~b;
      bus.op        = ~op;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin seen = 1'b1; break; end
      end
      if (!seen) chk("out_valid_timeout", bus.out_valid, 1);
      chk($sformatf("latency_op%0d", op), 64'(cyc - acc), 64'(el));
      for (int i = 0; i < int'(hold); i++) begin
         if (i > 0) @(negedge clk);
         chk("hold_result", bus.result, er);
         chk("hold_valid", bus.out_valid, 1);
         chk("hold_in_ready", bus.in_ready, 0);
         @(posedge clk); #1;
      end
      if (hold > 0) begin
         bus.out_ready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [32:0] addsub_model(input logic [31:0] a, input logic [31:0] b,
                                                input bit sub);
      longint v;
      v = sub ? longint'($signed(a)) - longint'($signed(b))
              : longint'($signed(a)) + longint'($signed(b));
      if (v > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
      if (v < -64'sd2147483648) return {1'b1, 32'h8000_0000};
      return {1'b0, v[31:0]};
   endfunction

   initial begin
      logic [31:0] ra, rb;
      logic [32:0] m;
      bit sub;
      bit seen;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.op        = '0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_flags", bus.flags, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      run_op(3'd0, 32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF, 3'b001, 1, 0);
      run_op(3'd2, 32'h0001_8000, 32'hFFFE_0000, 32'hFFFD_0000, 3'b000, 1, 0);
      run_op(3'd3, 32'h0007_0000, 32'h0002_0000, 32'h0003_8000, 3'b000, 49, 5);
      run_op(3'd3, 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 3'b011, 1, 0);
      run_op(3'd7, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 3'b100, 1, 0);
      run_op(3'd4, 32'h0003_0000, 32'h0, 32'h0001_8000, 3'b000, 1, 0);
      run_op(3'd4, 32'h0001_0000, 32'h0, 32'h0000_0000, 3'b000, 1, 0);
      run_op(3'd4, 32'h0000_0000, 32'h0, 32'h8000_0000, 3'b001, 1, 0);
      run_op(3'd4, 32'h0000_8000, 32'h0, 32'hFFFF_0000, 3'b000, 1, 0);
      run_op(3'd3, 32'hFFF9_0000, 32'h0002_0000, 32'hFFFC_8000, 3'b000, 49, 0);
      run_op(3'd3, 32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 3'b001, 49, 0);
      run_op(3'd3, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 3'b000, 49, 0);
      run_op(3'd1, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 3'b001, 1, 0);
      run_op(3'd2, 32'h0100_0000, 32'h0100_0000, 32'h7FFF_FFFF, 3'b001, 1, 0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 3'b000, 1, 0);
      run_op(3'd6, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF, 3'b001, 1, 0);
      run_op(3'd6, 32'hFFFF_8000, 32'h0, 32'h0000_8000, 3'b000, 1, 0);
      run_op(3'd5, 32'h0005_0000, 32'h0000_0000, 32'h0000_0000, 3'b010, 1, 0);
      run_op(3'd5, 32'h0005_0000, 32'h0003_0000, 32'h0002_0000, 3'b000, 1, 0);

      for (int i = 0; i < 8; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         sub = 1'($urandom_range(0, 1));
         m   = addsub_model(ra, rb, sub);
         run_op(sub ? 3'd1 : 3'd0, ra, rb, m[31:0], {2'b00, m[32]}, 1, 0);
      end

      // Reset mid-divide: the in-flight operation must vanish entirely.
      bus.op        = 3'd3;
      bus.operand_a = 32'h0007_0000;
      bus.operand_b = 32'h0002_0000;
      bus.in_valid  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin seen = 1'b1; break; end
      end
      if (!seen) chk("in_ready_timeout", bus.in_ready, 1);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_in_ready", bus.in_ready, 1);
      chk("midrst_result", bus.result, 0);
      chk("midrst_flags", bus.flags, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", bus.in_ready, 1);
      repeat (40) @(negedge clk);
      chk("post_rst_no_valid", bus.out_valid, 0);
      @(posedge clk); #1;
      run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 3'b000, 1, 0);

      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(sbq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, got=running expected=finished");
      $fatal(1, "watchdog expired");
   end
endmodule
